line_frame_counter: RTL and testbench
=====================================

// Module: line_frame_counter
// PURPOSE
//  Parametrised successor of the 5-bit line counter in the pattern-generator timing chain.
//  - Counts new_line strobes while enabled and wraps at a programmable frame height.
//  - Emits a one-cycle end_frame pulse at each wrap and keeps a frame counter.
//  - Supports free-run and single-shot modes and a shadowed height register.
//  - Sits between the pixel/line timing source and the pattern engines that need frame boundaries.
// PARAMETERS
//  LINE_W        5   width of line index; max frame height 2**LINE_W lines
//  FRAME_W       8   width of frame counter (wraps modulo 2**FRAME_W)
//  DEFAULT_LAST  31  reset value of last-line index (frame height = DEFAULT_LAST+1)
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  enb            in   1        count enable; low = hold all state
//  new_line       in   1        line strobe; each cycle high (with enb) counts one line
//  mode_single    in   1        0 = free-run, 1 = single-shot (stop after one frame)
//  restart        in   1        1-cycle: clear line_idx and done, re-arm single-shot
//  cfg_load       in   1        1-cycle: capture cfg_last into shadow register
//  cfg_last       in   LINE_W   new last-line index (frame height - 1)
//  line_idx       out  LINE_W   current line within frame
//  frame_cnt      out  FRAME_W  completed frames, modulo 2**FRAME_W
//  end_frame      out  1        registered pulse, high one cycle after the wrapping count
//  done           out  1        single-shot frame completed; counting frozen
//  cfg_pending    out  1        shadow captured, not yet applied
// BEHAVIOUR
//  Reset:
//   - line_idx=0, frame_cnt=0, end_frame=0, done=0, cfg_pending=0.
//   - active_last=DEFAULT_LAST, shadow=DEFAULT_LAST.
//  count = enb & new_line & ~done & ~restart.
//  Priority: rst > restart > count > hold.
//  Count, line_idx != active_last: line_idx+1.
//  Count, line_idx == active_last (wrap):
//   - line_idx<=0 and frame_cnt<=frame_cnt+1 (natural wrap).
//   - end_frame<=1 for exactly the next cycle.
//   - If mode_single: done<=1.
//  Shadow config:
//   - cfg_load captures cfg_last into shadow and sets cfg_pending.
//   - At the next wrap, active_last<=shadow and cfg_pending clears.
//   - cfg_load coinciding with a wrap bypasses: that cycle's cfg_last becomes active_last at this wrap.
//   - cfg_load with enb low is still captured.
//   - Multiple loads before a wrap: last one wins.
//  cfg_last=0: every counted line wraps, and end_frame pulses on every count.
//  restart:
//   - line_idx<=0, done<=0, end_frame<=0.
//   - frame_cnt unchanged; cfg_pending/shadow unchanged.
//   - A new_line in the same cycle is dropped.
//  enb low: line_idx, frame_cnt and done hold; end_frame is driven 0 (the pulse is never stretched).
//  mode_single is sampled only at wrap; changing it mid-frame affects the current frame's end.
//  done=1 with mode_single later cleared: stays frozen until restart.
//  Async rst mid-frame: all outputs return to reset values immediately; no pulse is emitted.
//  Latency: line_idx updates the cycle after the strobe; end_frame is coincident with line_idx=0 after a wrap.
// STRUCTURE
//  - Package line_frame_pkg holds LINE_W/FRAME_W defaults and DEFAULT_LAST, shared with pattern engines.
//  - Sub-module wrap_counter (width, load, enable, terminal value): instantiated for line_idx.
//  - frame_cnt, shadow register, done and end_frame logic stay in the top level.
// TESTING
//  1. Reset, enb=1, new_line=1 for 32 cycles, defaults -> line_idx 0..31; end_frame one cycle at wrap; frame_cnt=1.
//  2. new_line toggling every cycle with enb=1 for 60 cycles -> 30 counts, line_idx=30, no end_frame.
//     Then enb=0 for 60 cycles -> line_idx frozen at 30, end_frame=0.
//  3. cfg_load cfg_last=9 at line 5 -> cfg_pending=1; frame ends at line 31; next frame wraps after 10 lines.
//     Same test with load on the wrap cycle -> applied immediately.
//  4. mode_single=1, 32 counts -> end_frame pulse, done=1; further strobes ignored.
//     restart -> line_idx=0, done=0, counting resumes.
//  5. cfg_last=0, 5 strobes -> 5 end_frame pulses, frame_cnt=5.
//     FRAME_W=2 run of 5 frames -> frame_cnt=1.
//  6. rst asserted asynchronously at line 17 between edges -> line_idx=0, frame_cnt=0 with no clock edge.
//     restart together with new_line -> strobe dropped.

Source files
------------

// File: rtl/line_frame_counter_pkg.sv
// Shared defaults for the line/frame timing chain.
// Pattern engines import these so that their frame geometry matches the counter's.
package line_frame_pkg;

  // Width of the line index; the maximum frame height is 2**DFLT_LINE_W lines.
  localparam int unsigned DFLT_LINE_W  = 5;

  // Width of the completed-frame counter, which wraps modulo 2**DFLT_FRAME_W.
  localparam int unsigned DFLT_FRAME_W = 8;

  // Reset value of the last-line index, so the default frame height is DFLT_LAST+1.
  localparam int unsigned DFLT_LAST    = 31;

endpackage

// File: rtl/line_frame_counter_if.sv
// Control/status bundle between the timing source and line_frame_counter.
//   master : drives enb, new_line, mode_single, restart, cfg_load, cfg_last.
//            Observes line_idx, frame_cnt, end_frame, done, cfg_pending.
//   slave  : the counter itself, with the opposite directions.
interface line_frame_counter_if #(
  parameter int unsigned LINE_W  = line_frame_pkg::DFLT_LINE_W,
  parameter int unsigned FRAME_W = line_frame_pkg::DFLT_FRAME_W
);

  logic               enb;
  logic               new_line;
  logic               mode_single;
  logic               restart;
  logic               cfg_load;
  logic [LINE_W-1:0]  cfg_last;
  logic [LINE_W-1:0]  line_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               end_frame;
  logic               done;
  logic               cfg_pending;

  modport master (
    output enb, new_line, mode_single, restart, cfg_load, cfg_last,
    input  line_idx, frame_cnt, end_frame, done, cfg_pending
  );

  modport slave (
    input  enb, new_line, mode_single, restart, cfg_load, cfg_last,
    output line_idx, frame_cnt, end_frame, done, cfg_pending
  );

endinterface

// File: rtl/line_frame_counter_wrap_counter.sv
// Counter that wraps to zero after reaching a run-time terminal value.
// The synchronous load has priority over counting.
//   clk, rst : clock and asynchronous active-high reset
//   load     : synchronous load of load_val
//   load_val : value taken on load
//   en       : advance by one, or wrap when q == last
//   last     : terminal value
//   q        : registered count
//   wrap_c   : combinational; this cycle's count is the wrapping one
module wrap_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] q,
  output logic             wrap_c
);

  assign wrap_c = en && (q == last);

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= wrap_c ? '0 : q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/line_frame_counter.sv
// Line counter with a programmable frame height, a frame counter and an end-of-frame pulse.
// It supports free-run and single-shot modes. A new height loaded through the shadow
// register takes effect only at the next frame boundary.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of line_frame_counter_if (controls in, status out)
module line_frame_counter
  import line_frame_pkg::*;
#(
  parameter int unsigned LINE_W       = DFLT_LINE_W,
  parameter int unsigned FRAME_W      = DFLT_FRAME_W,
  parameter int unsigned DEFAULT_LAST = DFLT_LAST
) (
  input  logic                  clk,
  input  logic                  rst,
  line_frame_counter_if.slave   bus
);

  localparam logic [LINE_W-1:0] RST_LAST = LINE_W'(DEFAULT_LAST);

  logic              count_c;
  logic              wrap_c;
  logic [LINE_W-1:0] line_idx;
  logic [LINE_W-1:0] active_last;
  logic [LINE_W-1:0] shadow_last;

  // Restart drops a coincident strobe, and a completed single-shot frame freezes counting.
  assign count_c = bus.enb && bus.new_line && !bus.done && !bus.restart;

  // Line index within the frame.
  wrap_counter #(
    .WIDTH (LINE_W)
  ) u_line (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.restart),
    .load_val ('0),
    .en       (count_c),
    .last     (active_last),
    .q        (line_idx),
    .wrap_c   (wrap_c)
  );

  assign bus.line_idx = line_idx;

  // Height shadow: the frame height only changes on a wrap, so line_idx never passes active_last.
  // A load on the wrap cycle itself bypasses the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_last     <= RST_LAST;
      shadow_last     <= RST_LAST;
      bus.cfg_pending <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        shadow_last <= bus.cfg_last;
      end
      if (wrap_c) begin
        if (bus.cfg_load) begin
          active_last <= bus.cfg_last;
        end else if (bus.cfg_pending) begin
          active_last <= shadow_last;
        end
        bus.cfg_pending <= 1'b0;
      end else if (bus.cfg_load) begin
        bus.cfg_pending <= 1'b1;
      end
    end
  end

  // Frame count, end-of-frame pulse and single-shot completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.frame_cnt <= '0;
      bus.end_frame <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.end_frame <= wrap_c;
      if (wrap_c) begin
        bus.frame_cnt <= bus.frame_cnt + FRAME_W'(1);
      end
      if (bus.restart) begin
        bus.done <= 1'b0;
      end else if (wrap_c && bus.mode_single) begin
        bus.done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_frame_counter.sv
// Self-checking bench for line_frame_counter: a directed vector table, hand-written
// multi-cycle corner sequences, and a randomized run against a reference model.
module tb_line_frame_counter;

  localparam int unsigned LW = 5;
  localparam int unsigned FW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_frame_counter_if #(.LINE_W(LW), .FRAME_W(FW)) b1 ();
  line_frame_counter_if #(.LINE_W(LW), .FRAME_W(2))  b2 ();

  line_frame_counter #(.LINE_W(LW), .FRAME_W(FW), .DEFAULT_LAST(31)) dut (
    .clk (clk), .rst (rst), .bus (b1)
  );

  line_frame_counter #(.LINE_W(LW), .FRAME_W(2), .DEFAULT_LAST(1)) dut2 (
    .clk (clk), .rst (rst), .bus (b2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit enb; bit nl; bit ms; bit rs; bit ld; int last; int rep;
    int e_line; int e_end; int e_done; int e_pend; int e_frame;
  } vec_t;

  vec_t tbl[$];

  // Reference model state.
  int m_line, m_frame, m_end, m_done, m_pend, m_shadow, m_active;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit enb, input bit nl, input bit ms, input bit rs,
                       input bit ld, input int last);
    b1.enb = enb; b1.new_line = nl; b1.mode_single = ms;
    b1.restart = rs; b1.cfg_load = ld; b1.cfg_last = LW'(last);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    b2.enb = 0; b2.new_line = 0; b2.mode_single = 0;
    b2.restart = 0; b2.cfg_load = 0; b2.cfg_last = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_line = 0; m_frame = 0; m_end = 0; m_done = 0; m_pend = 0;
    m_shadow = 31; m_active = 31;
  endtask

  // One clock of the behaviour: restart wins, then counting, and the height changes only at a wrap.
  task automatic model_step(input bit enb, input bit nl, input bit ms, input bit rs,
                            input bit ld, input int last);
    bit cnt, wrap;
    cnt   = enb && nl && (m_done == 0) && !rs;
    wrap  = cnt && (m_line == m_active);
    m_end = wrap ? 1 : 0;
    if (rs) begin
      m_line = 0; m_done = 0;
    end else if (cnt) begin
      if (wrap) begin
        m_line  = 0;
        m_frame = (m_frame + 1) % 256;
        if (ms) m_done = 1;
      end else begin
        m_line = m_line + 1;
      end
    end
    if (wrap) begin
      if (ld) begin m_active = last; m_shadow = last; end
      else m_active = m_shadow;
      m_pend = 0;
    end else if (ld) begin
      m_shadow = last; m_pend = 1;
    end
  endtask

  function automatic vec_t mk(bit enb, bit nl, bit ms, bit rs, bit ld, int last, int rep,
                              int e_line, int e_end, int e_done, int e_pend, int e_frame);
    vec_t v;
    v.enb = enb; v.nl = nl; v.ms = ms; v.rs = rs; v.ld = ld; v.last = last; v.rep = rep;
    v.e_line = e_line; v.e_end = e_end; v.e_done = e_done; v.e_pend = e_pend; v.e_frame = e_frame;
    return v;
  endfunction

  initial begin
    bit any_end;

    // Directed table, applied from reset (default height 32).
    tbl.push_back(mk(1,1,0,0,0,0, 5,   5,0,0,0,0));   // five lines
    tbl.push_back(mk(1,1,0,0,1,9, 1,   6,0,0,1,0));   // load 9 mid-frame, held pending
    tbl.push_back(mk(1,1,0,0,0,0, 25, 31,0,0,1,0));   // reach old last line
    tbl.push_back(mk(1,1,0,0,0,0, 1,   0,1,0,0,1));   // wrap at 31, shadow applied
    tbl.push_back(mk(1,1,0,0,0,0, 9,   9,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0, 1,   0,1,0,0,2));   // 10-line frame
    tbl.push_back(mk(1,1,0,0,0,0, 9,   9,0,0,0,2));
    tbl.push_back(mk(1,1,0,0,1,0, 1,   0,1,0,0,3));   // load on wrap cycle bypasses
    tbl.push_back(mk(1,1,0,0,0,0, 5,   0,1,0,0,8));   // height 1: every count wraps
    tbl.push_back(mk(1,0,0,0,0,0, 1,   0,0,0,0,8));
    tbl.push_back(mk(0,1,0,0,1,3, 1,   0,0,0,1,8));   // load captured with enb low
    tbl.push_back(mk(0,0,0,0,1,4, 1,   0,0,0,1,8));   // last load wins
    tbl.push_back(mk(1,1,1,0,0,0, 1,   0,1,1,0,9));   // single-shot wrap
    tbl.push_back(mk(1,1,0,0,0,0, 3,   0,0,1,0,9));   // frozen after clearing mode
    tbl.push_back(mk(1,1,0,1,0,0, 1,   0,0,0,0,9));   // restart drops strobe
    tbl.push_back(mk(1,1,0,0,0,0, 4,   4,0,0,0,9));
    tbl.push_back(mk(1,1,0,0,0,0, 1,   0,1,0,0,10));  // height 5 from last load
    tbl.push_back(mk(1,1,0,0,0,0, 2,   2,0,0,0,10));
    tbl.push_back(mk(1,1,0,1,0,0, 1,   0,0,0,0,10));  // restart mid-frame
    tbl.push_back(mk(1,1,0,0,0,0, 1,   1,0,0,0,10));

    do_reset();
    chk("reset line_idx", b1.line_idx, 0);
    chk("reset frame_cnt", b1.frame_cnt, 0);
    chk("reset end_frame", b1.end_frame, 0);
    chk("reset done", b1.done, 0);
    chk("reset cfg_pending", b1.cfg_pending, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].enb, tbl[i].nl, tbl[i].ms, tbl[i].rs, tbl[i].ld, tbl[i].last);
      repeat (tbl[i].rep) step();
      chk($sformatf("vec%0d line_idx", i), b1.line_idx, tbl[i].e_line);
      chk($sformatf("vec%0d end_frame", i), b1.end_frame, tbl[i].e_end);
      chk($sformatf("vec%0d done", i), b1.done, tbl[i].e_done);
      chk($sformatf("vec%0d cfg_pending", i), b1.cfg_pending, tbl[i].e_pend);
      chk($sformatf("vec%0d frame_cnt", i), b1.frame_cnt, tbl[i].e_frame);
    end

    // Full default frame.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step();
      chk($sformatf("full line %0d", i), b1.line_idx, (i + 1) % 32);
      chk($sformatf("full end %0d", i), b1.end_frame, (i == 31) ? 1 : 0);
    end
    chk("full frame_cnt", b1.frame_cnt, 1);
    step();
    chk("full end pulse width", b1.end_frame, 0);

    // Toggling strobe, then enable low.
    do_reset();
    any_end = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1, (i % 2) == 0, 0, 0, 0, 0);
      step();
      if (b1.end_frame) any_end = 1;
    end
    chk("toggle line_idx", b1.line_idx, 30);
    chk("toggle no end_frame", any_end, 0);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step();
      if (b1.end_frame) any_end = 1;
    end
    chk("enb low line_idx", b1.line_idx, 30);
    chk("enb low no end_frame", any_end, 0);

    // Single-shot frame, then restart.
    do_reset();
    drive(1, 1, 1, 0, 0, 0);
    repeat (32) step();
    chk("single end_frame", b1.end_frame, 1);
    chk("single done", b1.done, 1);
    chk("single frame_cnt", b1.frame_cnt, 1);
    repeat (5) step();
    chk("single frozen line", b1.line_idx, 0);
    chk("single frozen frame", b1.frame_cnt, 1);
    chk("single frozen end", b1.end_frame, 0);
    drive(1, 0, 1, 1, 0, 0);
    step();
    chk("restart done", b1.done, 0);
    drive(1, 1, 1, 0, 0, 0);
    repeat (3) step();
    chk("resume line_idx", b1.line_idx, 3);

    // Narrow frame counter wraps modulo 4 (height 2, 5 frames).
    do_reset();
    b2.enb = 1; b2.new_line = 1;
    repeat (10) step();
    chk("narrow frame_cnt", b2.frame_cnt, 1);
    chk("narrow line_idx", b2.line_idx, 0);
    b2.enb = 0; b2.new_line = 0;

    // Asynchronous reset between edges.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    repeat (49) step();
    chk("pre-rst line_idx", b1.line_idx, 17);
    chk("pre-rst frame_cnt", b1.frame_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst line_idx", b1.line_idx, 0);
    chk("async rst frame_cnt", b1.frame_cnt, 0);
    chk("async rst end_frame", b1.end_frame, 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk("post-rst line_idx", b1.line_idx, 0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit r_enb, r_nl, r_ms, r_rs, r_ld;
      int r_last;
      r_enb  = $urandom_range(0, 7) != 0;
      r_nl   = $urandom_range(0, 3) != 0;
      r_ms   = $urandom_range(0, 3) == 0;
      r_rs   = $urandom_range(0, 15) == 0;
      r_ld   = $urandom_range(0, 7) == 0;
      r_last = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, 7));
      drive(r_enb, r_nl, r_ms, r_rs, r_ld, r_last);
      step();
      model_step(r_enb, r_nl, r_ms, r_rs, r_ld, r_last);
      chk($sformatf("rand%0d line_idx", i), b1.line_idx, m_line);
      chk($sformatf("rand%0d frame_cnt", i), b1.frame_cnt, m_frame);
      chk($sformatf("rand%0d end_frame", i), b1.end_frame, m_end);
      chk($sformatf("rand%0d done", i), b1.done, m_done);
      chk($sformatf("rand%0d cfg_pending", i), b1.cfg_pending, m_pend);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
